// File: rtl/fifo_wptr_full_p.sv
// fifo_wptr_full_p: async FIFO write-side controller (Gray write pointer, full, level, overflow); FIFO_WLEVEL_EN adds wlevel/walmost_full
module fifo_wptr_full_p #(
    parameter int ADDR_W       = 4,
    parameter int AFULL_MARGIN = 4
) (
    input  logic              wclk,
    input  logic              wrst_n,
    input  logic              winc,
    input  logic              wovf_clr,
    input  logic [ADDR_W:0]   wq2_rptr,
    output logic [ADDR_W-1:0] waddr,
    output logic              wclken,
    output logic [ADDR_W:0]   wptr,
    output logic              wfull,
    output logic              walmost_full,
    output logic [ADDR_W:0]   wlevel,
    output logic              woverflow
);
    logic [ADDR_W:0] wbin;
    logic [ADDR_W:0] wbin_next;
    logic [ADDR_W:0] wgray_next;
    logic            full_next;
    logic            ovf_next;

    assign wclken     = winc & ~wfull;
    assign waddr      = wbin[ADDR_W-1:0];
    assign wbin_next  = wbin + (ADDR_W+1)'(wclken);
    assign wgray_next = (wbin_next >> 1) ^ wbin_next;
    // Full when the next write pointer sits exactly one lap ahead of the read pointer, compared in Gray
    assign full_next  = wgray_next == {~wq2_rptr[ADDR_W:ADDR_W-1], wq2_rptr[ADDR_W-2:0]};
    // Set has priority over clear so an overflow in the clearing cycle is never lost
    assign ovf_next   = (winc & wfull) | (woverflow & ~wovf_clr);

    // Pointer, full and overflow state
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin      <= '0;
            wptr      <= '0;
            wfull     <= 1'b0;
            woverflow <= 1'b0;
        end else begin
            wbin      <= wbin_next;
            wptr      <= wgray_next;
            wfull     <= full_next;
            woverflow <= ovf_next;
        end
    end

`ifdef FIFO_WLEVEL_EN
    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] AFULL_THR = (ADDR_W+1)'(DEPTH - AFULL_MARGIN);
    logic [ADDR_W:0] rbin;
    logic [ADDR_W:0] level_next;

    // Gray-to-binary of the synchronised read pointer: each bit is the XOR of itself and all bits above
    always_comb begin
        rbin = '0;
        for (int i = 0; i <= ADDR_W; i++) rbin[i] = ^(wq2_rptr >> i);
    end

    assign level_next = wbin_next - rbin;

    // Occupancy estimate and almost-full flag, pessimistic because rbin lags
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wlevel       <= '0;
            walmost_full <= 1'b0;
        end else begin
            wlevel       <= level_next;
            walmost_full <= level_next >= AFULL_THR;
        end
    end
`else
    assign wlevel       = '0;
    assign walmost_full = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_wptr_full_p.sv
// tb_fifo_wptr_full_p: directed and random checks of the write-side controller against a counting model
module tb_fifo_wptr_full_p;
    localparam int AW = 4;
    localparam int D  = 1 << AW;
    localparam int M  = 4;

    logic          wclk = 1'b0;
    logic          wrst_n = 1'b0;
    logic          winc = 1'b0;
    logic          wovf_clr = 1'b0;
    logic [AW:0]   wq2_rptr = '0;
    logic [AW-1:0] waddr;
    logic          wclken;
    logic [AW:0]   wptr;
    logic          wfull;
    logic          walmost_full;
    logic [AW:0]   wlevel;
    logic          woverflow;

    int   vectors = 0;
    int   errs = 0;
    int   wcnt = 0;
    int   rcnt = 0;
    int   occ = 0;
    bit   m_full = 0;
    bit   m_ovf = 0;
    logic [AW:0] prev_wptr = '0;

    fifo_wptr_full_p #(.ADDR_W(AW), .AFULL_MARGIN(M)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wovf_clr(wovf_clr),
        .wq2_rptr(wq2_rptr), .waddr(waddr), .wclken(wclken), .wptr(wptr),
        .wfull(wfull), .walmost_full(walmost_full), .wlevel(wlevel), .woverflow(woverflow)
    );

    always #5 wclk = ~wclk;

    function automatic logic [AW:0] gray(input int b);
        logic [AW:0] v;
        v = (AW+1)'(b % (2 * D));
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs();
`ifdef FIFO_WLEVEL_EN
        chk("wlevel", 32'(wlevel), 32'(occ));
        chk("walmost_full", 32'(walmost_full), 32'(occ >= D - M));
`else
        chk("wlevel", 32'(wlevel), 32'd0);
        chk("walmost_full", 32'(walmost_full), 32'd0);
`endif
        chk("wptr", 32'(wptr), 32'(gray(wcnt)));
        chk("wfull", 32'(wfull), 32'(m_full));
        chk("woverflow", 32'(woverflow), 32'(m_ovf));
        chk("gray_step", 32'($countones(prev_wptr ^ wptr) <= 1), 32'd1);
        prev_wptr = wptr;
    endtask

    task automatic step(input bit inc, input bit clr);
        bit acc;
        @(negedge wclk);
        winc = inc;
        wovf_clr = clr;
        wq2_rptr = gray(rcnt);
        #1;
        acc = inc && !m_full;
        chk("wclken", 32'(wclken), 32'(acc));
        chk("waddr", 32'(waddr), 32'(wcnt % D));
        @(posedge wclk);
        m_ovf = (inc && m_full) || (m_ovf && !clr);
        if (acc) wcnt++;
        occ = (wcnt - rcnt) % (2 * D);
        m_full = occ == D;
        #1;
        chk_regs();
    endtask

    task automatic pulse_reset();
        @(negedge wclk);
        winc = 1'b0;
        wovf_clr = 1'b0;
        #2 wrst_n = 1'b0;
        #1;
        wcnt = 0; rcnt = 0; occ = 0; m_full = 0; m_ovf = 0; prev_wptr = '0;
        wq2_rptr = '0;
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk_regs();
        #1 wrst_n = 1'b1;
    endtask

    initial begin
        #2;
        chk("reset_waddr", 32'(waddr), 32'd0);
        chk_regs();
        @(negedge wclk);
        wrst_n = 1'b1;
        // fill from empty
        for (int i = 1; i <= D; i++) begin
            step(1, 0);
            if (i == D - M) chk("af_at_12", 32'(walmost_full), 32'(`ifdef FIFO_WLEVEL_EN 1 `else 0 `endif));
        end
        chk("full_after_16", 32'(wfull), 32'd1);
        chk("wptr_full", 32'(wptr), 32'b11000);
        // writes while full are rejected and flagged
        for (int i = 0; i < 3; i++) step(1, 0);
        chk("ovf_set", 32'(woverflow), 32'd1);
        step(0, 1);
        chk("ovf_clr", 32'(woverflow), 32'd0);
        // read pointer advances by three
        rcnt = 3;
        step(0, 0);
        chk("release_full", 32'(wfull), 32'd0);
        for (int i = 0; i < 3; i++) step(1, 0);
        chk("refull", 32'(wfull), 32'd1);
        // set wins over clear
        step(1, 1);
        chk("ovf_set_wins", 32'(woverflow), 32'd1);
        step(0, 1);
        // wrap with reader trailing by two
        for (int i = 0; i < 40; i++) begin
            rcnt = wcnt - 2;
            step(1, 0);
        end
        // random traffic
        for (int i = 0; i < 400; i++) begin
            rcnt = rcnt + $urandom_range(0, (wcnt - rcnt) > 2 ? 2 : (wcnt - rcnt));
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
        end
        // reset in the middle of filling
        pulse_reset();
        for (int i = 0; i < 7; i++) step(1, 0);
        pulse_reset();
        step(1, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
